// File: rtl/jtframe_frame_pkg.sv
// Shared types for the frame tracker.
// FSM state encoding and default stall timeout.
package jtframe_frame_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SYNC,
    RUN,
    DONE
  } state_t;

  localparam int VS_TIMEOUT_DEF = 2_000_000;

endpackage

// File: rtl/jtframe_frame_tracker_if.sv
// Signal bundle between the frame tracker and its user.
// The user drives vs/dwnld; the tracker returns frame status.
interface jtframe_frame_tracker_if #(
  parameter int LENW = 24
);

  logic            vs;
  logic            dwnld;
  logic [31:0]     frame_cnt;
  logic            vs_fall;
  logic            dump_en;
  logic            finish;
  logic [LENW-1:0] frame_len;
  logic            frame_len_vld;
  logic            stall;

  modport master (
    output vs,
    output dwnld,
    input  frame_cnt,
    input  vs_fall,
    input  dump_en,
    input  finish,
    input  frame_len,
    input  frame_len_vld,
    input  stall
  );

  modport slave (
    input  vs,
    input  dwnld,
    output frame_cnt,
    output vs_fall,
    output dump_en,
    output finish,
    output frame_len,
    output frame_len_vld,
    output stall
  );

endinterface

// File: rtl/jtframe_sync_edge.sv
// Three-flop VS synchroniser with falling-edge detect.
// fall_d is the raw edge term, fall its registered strobe.
module jtframe_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic fall_d,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s3   <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1   <= vs;
      s2   <= s1;
      s3   <= s2;
      fall <= fall_d;
    end
  end

  assign fall_d = s3 & ~s2;

endmodule

// File: rtl/jtframe_frame_tracker.sv
// Frame counter, dump window, frame length and stall
// detection driven by the synchronised VS falling edge.
module jtframe_frame_tracker
  import jtframe_frame_pkg::*;
#(
  parameter int DUMP_START = 0,
  parameter int DUMP_END   = 0,
  parameter int LENW       = 24,
  parameter int VS_TIMEOUT = VS_TIMEOUT_DEF
) (
  input logic                    clk,
  input logic                    rst,
  jtframe_frame_tracker_if.slave bus
);

  localparam logic [LENW-1:0] TO_LEN  = LENW'(VS_TIMEOUT);
  localparam logic [LENW-1:0] LEN_MAX = '1;
  localparam logic [LENW-1:0] LEN_ONE = LENW'(1);

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     cnt;
  logic [31:0]     cnt_inc;
  logic [LENW-1:0] len_cnt;
  logic [LENW-1:0] frame_len;
  logic            fall_d;
  logic            fall;
  logic            frame_len_vld;
  logic            finish;
  logic            stall;
  logic            ge_start;
  logic            lt_end;
  logic            hit_end;
  logic            dump_en;

  jtframe_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .vs     (bus.vs),
    .fall_d (fall_d),
    .fall   (fall)
  );

  assign cnt_inc = cnt + 32'd1;

  // Window bounds resolved at elaboration so unused limits cost nothing
  if (DUMP_START == 0) begin : g_no_start
    assign ge_start = 1'b1;
  end else begin : g_start
    assign ge_start = cnt >= 32'(DUMP_START);
  end

  if (DUMP_END == 0) begin : g_no_end
    assign lt_end  = 1'b1;
    assign hit_end = 1'b0;
  end else begin : g_end
    assign lt_end  = cnt < 32'(DUMP_END);
    assign hit_end = cnt_inc == 32'(DUMP_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.dwnld) begin
      state_nxt = LOAD;
    end else begin
      unique case (state)
        LOAD: state_nxt = SYNC;
        SYNC: if (fall_d) state_nxt = RUN;
        RUN:  if (fall_d && hit_end) state_nxt = DONE;
        DONE: state_nxt = DONE;
      endcase
    end
  end

  always_comb begin
    dump_en = (state == RUN) && ge_start && lt_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      len_cnt       <= '0;
      frame_len     <= '0;
      frame_len_vld <= 1'b0;
      finish        <= 1'b0;
      stall         <= 1'b0;
    end else begin
      frame_len_vld <= 1'b0;
      finish        <= 1'b0;
      if (bus.dwnld || state == LOAD) begin
        cnt     <= '0;
        len_cnt <= '0;
        stall   <= 1'b0;
      end else if (state == SYNC) begin
        // first edge only aligns the length counter
        if (fall_d) len_cnt <= LEN_ONE;
      end else if (fall_d) begin
        cnt           <= cnt_inc;
        frame_len     <= len_cnt;
        len_cnt       <= LEN_ONE;
        frame_len_vld <= 1'b1;
        stall         <= 1'b0;
        finish        <= (state == RUN) && hit_end;
      end else begin
        if (len_cnt != LEN_MAX) len_cnt <= len_cnt + LEN_ONE;
        if (len_cnt == TO_LEN)  stall   <= 1'b1;
      end
    end
  end

  assign bus.frame_cnt     = cnt;
  assign bus.vs_fall       = fall;
  assign bus.dump_en       = dump_en;
  assign bus.finish        = finish;
  assign bus.frame_len     = frame_len;
  assign bus.frame_len_vld = frame_len_vld;
  assign bus.stall         = stall;

endmodule

// File: tb/tb_jtframe_frame_tracker.sv
// Scenario tasks with constant expectations, then a random
// run checked against an edge-indexed reference model.
module tb_jtframe_frame_tracker;
  import jtframe_frame_pkg::*;

  localparam int DS = 2;
  localparam int DE = 4;
  localparam int TO = 500;
  localparam int LW = 24;
  localparam int LENMAX = (1 << LW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jtframe_frame_tracker_if #(.LENW(LW)) bus ();

  jtframe_frame_tracker #(
    .DUMP_START (DS),
    .DUMP_END   (DE),
    .LENW       (LW),
    .VS_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: indexed by post-reset clock edge number
  bit          vs_hist[$];
  int          m_n;
  int          m_mode;
  bit          m_done;
  logic [31:0] m_cnt;
  int          m_last;
  logic [LW-1:0] m_len;
  bit          e_fall, e_vld, e_fin, e_stall;

  function automatic bit samp(int i);
    return (i < 0) ? 1'b1 : vs_hist[i];
  endfunction

  task automatic model_step();
    bit f;
    if (rst) begin
      vs_hist.delete();
      m_n = 0; m_mode = 0; m_done = 0; m_cnt = 0;
      m_last = 0; m_len = 0;
      e_fall = 0; e_vld = 0; e_fin = 0; e_stall = 0;
    end else begin
      vs_hist.push_back(bus.vs);
      f = !samp(m_n - 2) && samp(m_n - 3);
      e_fall = f; e_vld = 0; e_fin = 0;
      if (bus.dwnld) begin
        m_mode = 0; m_cnt = 0; m_done = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (f) begin m_mode = 2; m_last = m_n; end
      end else if (f) begin
        e_vld = 1;
        m_len = (m_n - m_last > LENMAX) ? LW'(LENMAX) : LW'(m_n - m_last);
        m_cnt = m_cnt + 1;
        m_last = m_n;
        if (DE != 0 && m_cnt == DE && !m_done) begin
          e_fin = 1; m_done = 1;
        end
      end
      e_stall = (m_mode == 2) && (m_n - m_last >= TO);
      m_n++;
    end
  endtask

  always @(posedge clk) model_step();

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 8;
    if (bus.frame_cnt !== 32'd0) begin n_err++; $display("FAIL reset_frame_cnt got %0h want 0", bus.frame_cnt); end
    if (bus.vs_fall !== 1'b0) begin n_err++; $display("FAIL reset_vs_fall got %b want 0", bus.vs_fall); end
    if (bus.dump_en !== 1'b0) begin n_err++; $display("FAIL reset_dump_en got %b want 0", bus.dump_en); end
    if (bus.finish !== 1'b0) begin n_err++; $display("FAIL reset_finish got %b want 0", bus.finish); end
    if (bus.frame_len !== '0) begin n_err++; $display("FAIL reset_frame_len got %0d want 0", bus.frame_len); end
    if (bus.frame_len_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", bus.frame_len_vld); end
    if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    if (dut.state !== LOAD) begin n_err++; $display("FAIL reset_state got %0d want LOAD", dut.state); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.frame_cnt !== 32'd0) begin n_err++; $display("FAIL load_frame_cnt got %0h want 0", bus.frame_cnt); end
  endtask

  task automatic test_count();
    int strobes = 0, vlds = 0, fins = 0, rises = 0, de_cyc = 0;
    int last_c = -1;
    bit prev_stall = 0;
    bus.dwnld = 1'b0;
    for (int c = 0; c < 6010; c++) begin
      @(negedge clk);
      bus.vs = ((c % 1000) < 4 && c < 6000) ? 1'b0 : 1'b1;
      if (bus.vs_fall) begin
        n_cmp += 2;
        if (bus.frame_cnt !== 32'(strobes)) begin n_err++; $display("FAIL count_frame_cnt got %0d want %0d", bus.frame_cnt, strobes); end
        if (bus.stall !== 1'b0) begin n_err++; $display("FAIL count_stall_clear got %b want 0", bus.stall); end
        strobes++;
        last_c = c;
      end
      if (bus.frame_len_vld) begin
        vlds++;
        n_cmp++;
        if (bus.frame_len !== LW'(1000)) begin n_err++; $display("FAIL count_frame_len got %0d want 1000", bus.frame_len); end
      end
      if (bus.finish) begin
        fins++;
        n_cmp++;
        if (bus.frame_cnt !== 32'd4) begin n_err++; $display("FAIL finish_cnt got %0d want 4", bus.frame_cnt); end
      end
      if (bus.dump_en) begin
        de_cyc++;
        n_cmp++;
        if (bus.frame_cnt !== 32'd2 && bus.frame_cnt !== 32'd3) begin n_err++; $display("FAIL dump_window got cnt %0d want 2 or 3", bus.frame_cnt); end
      end
      if (bus.stall && !prev_stall) begin
        rises++;
        n_cmp++;
        if (c - last_c !== TO) begin n_err++; $display("FAIL stall_delay got %0d want %0d", c - last_c, TO); end
      end
      prev_stall = bus.stall;
    end
    n_cmp += 6;
    if (strobes !== 6) begin n_err++; $display("FAIL count_strobes got %0d want 6", strobes); end
    if (vlds !== 5) begin n_err++; $display("FAIL count_vld got %0d want 5", vlds); end
    if (fins !== 1) begin n_err++; $display("FAIL count_finish got %0d want 1", fins); end
    if (de_cyc !== 2000) begin n_err++; $display("FAIL dump_cycles got %0d want 2000", de_cyc); end
    if (rises !== 6) begin n_err++; $display("FAIL stall_rises got %0d want 6", rises); end
    if (bus.frame_cnt !== 32'd5) begin n_err++; $display("FAIL count_final got %0d want 5", bus.frame_cnt); end
  endtask

  task automatic test_dwnld_collision();
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); bus.vs = 1'b0;
      repeat (4) @(negedge clk);
      bus.vs = 1'b1;
      repeat (300) @(negedge clk);
    end
    n_cmp++;
    if (bus.frame_cnt !== 32'd7) begin n_err++; $display("FAIL coll_pre_cnt got %0d want 7", bus.frame_cnt); end
    @(negedge clk); bus.vs = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.dwnld = 1'b1;
    @(negedge clk);
    n_cmp += 6;
    if (bus.vs_fall !== 1'b1) begin n_err++; $display("FAIL coll_vs_fall got %b want 1", bus.vs_fall); end
    if (bus.frame_len_vld !== 1'b0) begin n_err++; $display("FAIL coll_vld got %b want 0", bus.frame_len_vld); end
    if (bus.frame_cnt !== 32'd0) begin n_err++; $display("FAIL coll_cnt got %0d want 0", bus.frame_cnt); end
    if (bus.finish !== 1'b0) begin n_err++; $display("FAIL coll_finish got %b want 0", bus.finish); end
    if (bus.stall !== 1'b0) begin n_err++; $display("FAIL coll_stall got %b want 0", bus.stall); end
    if (dut.state !== LOAD) begin n_err++; $display("FAIL coll_state got %0d want LOAD", dut.state); end
    bus.vs = 1'b1;
    repeat (3) @(negedge clk);
    bus.dwnld = 1'b0;
  endtask

  task automatic test_glitch();
    int n, lat;
    @(negedge clk); bus.vs = 1'b0;
    repeat (4) @(negedge clk);
    bus.vs = 1'b1;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (dut.state !== RUN) begin n_err++; $display("FAIL glitch_run got %0d want RUN", dut.state); end
    // shorter than a clock, never sampled
    @(negedge clk); #1 bus.vs = 1'b0; #2 bus.vs = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus.vs_fall) n++; end
    n_cmp++;
    if (n !== 0) begin n_err++; $display("FAIL glitch_sub got %0d strobes want 0", n); end
    @(negedge clk); bus.vs = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.vs = 1'b1;
      if (bus.vs_fall) n++;
    end
    n_cmp++;
    if (n > 1) begin n_err++; $display("FAIL glitch_1clk got %0d strobes want <=1", n); end
    @(negedge clk); bus.vs = 1'b0;
    n = 0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) bus.vs = 1'b1;
      if (bus.vs_fall) begin n++; if (lat < 0) lat = i; end
    end
    n_cmp += 2;
    if (n !== 1) begin n_err++; $display("FAIL glitch_2clk got %0d strobes want 1", n); end
    if (lat !== 3) begin n_err++; $display("FAIL glitch_latency got %0d want 3", lat); end
    @(negedge clk); bus.vs = 1'b0;
    n = 0;
    for (int i = 0; i < 10000; i++) begin @(negedge clk); if (bus.vs_fall) n++; end
    bus.vs = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus.vs_fall) n++; end
    n_cmp++;
    if (n !== 1) begin n_err++; $display("FAIL glitch_long got %0d strobes want 1", n); end
  endtask

  task automatic test_wrap();
    bit seen = 0;
    @(negedge clk);
    force dut.cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.cnt;
    @(negedge clk);
    n_cmp += 2;
    if (bus.frame_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_pre got %0h want ffffffff", bus.frame_cnt); end
    if (bus.dump_en !== 1'b0) begin n_err++; $display("FAIL wrap_pre_dump got %b want 0", bus.dump_en); end
    bus.vs = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (i == 4) bus.vs = 1'b1;
      if (bus.vs_fall) begin
        seen = 1;
        n_cmp += 4;
        if (bus.frame_cnt !== 32'd0) begin n_err++; $display("FAIL wrap_cnt got %0h want 0", bus.frame_cnt); end
        if (bus.finish !== 1'b0) begin n_err++; $display("FAIL wrap_finish got %b want 0", bus.finish); end
        if (bus.dump_en !== 1'b0) begin n_err++; $display("FAIL wrap_dump got %b want 0", bus.dump_en); end
        if (dut.state !== RUN) begin n_err++; $display("FAIL wrap_state got %0d want RUN", dut.state); end
      end
    end
    bus.vs = 1'b1;
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL wrap_timeout got no strobe want 1"); end
  endtask

  task automatic test_random();
    int left = 0, dw_left = 0;
    bit lowph = 0, exp_de;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      exp_de = (m_mode == 2) && !m_done && (m_cnt >= DS) && (DE == 0 || m_cnt < DE);
      n_cmp += 7;
      if (bus.vs_fall !== e_fall) begin n_err++; $display("FAIL rnd_vs_fall c=%0d got %b want %b", c, bus.vs_fall, e_fall); end
      if (bus.frame_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt c=%0d got %0d want %0d", c, bus.frame_cnt, m_cnt); end
      if (bus.dump_en !== exp_de) begin n_err++; $display("FAIL rnd_dump c=%0d got %b want %b", c, bus.dump_en, exp_de); end
      if (bus.finish !== e_fin) begin n_err++; $display("FAIL rnd_finish c=%0d got %b want %b", c, bus.finish, e_fin); end
      if (bus.frame_len !== m_len) begin n_err++; $display("FAIL rnd_len c=%0d got %0d want %0d", c, bus.frame_len, m_len); end
      if (bus.frame_len_vld !== e_vld) begin n_err++; $display("FAIL rnd_vld c=%0d got %b want %b", c, bus.frame_len_vld, e_vld); end
      if (bus.stall !== e_stall) begin n_err++; $display("FAIL rnd_stall c=%0d got %b want %b", c, bus.stall, e_stall); end
      if (dw_left > 0) begin
        dw_left--;
        bus.dwnld = 1'b1;
      end else begin
        bus.dwnld = 1'b0;
        if ($urandom_range(1499, 0) == 0) dw_left = $urandom_range(5, 1);
      end
      if (left == 0) begin
        lowph = !lowph;
        left = lowph ? $urandom_range(6, 1) : $urandom_range(700, 20);
      end
      bus.vs = !lowph;
      left--;
    end
  endtask

  initial begin
    bus.vs = 1'b1;
    bus.dwnld = 1'b1;
    test_reset();
    test_count();
    test_dwnld_collision();
    test_glitch();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_frame_tracker.md
# jtframe_frame_tracker

Frame-tracking stage that feeds the simulation dump controller and the test harness. It synchronises the raw vertical-sync input and detects its falling edges, holding the count at zero while the ROM download is active. It produces `frame_cnt`, a per-frame strobe, a dump-window enable, a frame-length measurement and a stalled-video flag. It is synthesizable so the same frame count can drive on-board debug as well as simulation dumping.

## Interface
- `DUMP_START`, 0: first frame (inclusive) of the dump window.
- `DUMP_END`, 0: frame at which the dump window closes; 0 means never close.
- `LENW`, 24: width of the frame-length counter.
- `VS_TIMEOUT`, 2_000_000: clocks without a VS falling edge before `stall` sets; must be < 2^LENW.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `vs`  in  1  raw vertical sync, asynchronous to `clk`, active-low pulse
- `dwnld`  in  1  ROM download in progress (the LED/download signal), level, synchronous
- `frame_cnt`  out  32  frames completed since download end
- `vs_fall`  out  1  one-cycle strobe per detected VS falling edge
- `dump_en`  out  1  dump window open
- `finish`  out  1  one-cycle strobe when `frame_cnt` reaches `DUMP_END`
- `frame_len`  out  LENW  clocks between the last two VS falling edges
- `frame_len_vld`  out  1  one-cycle strobe when `frame_len` updates
- `stall`  out  1  no VS edge for `VS_TIMEOUT` clocks while running

## Operation
- Synchroniser: 3-flop chain s1←vs, s2←s1, s3←s2. The falling-edge term is s3 & ~s2. `vs_fall` is the registered version of that term.
- FSM states:
  - LOAD: entered on reset, and from any state when `dwnld`=1. Clears `frame_cnt`, `len_cnt` and `stall`.
  - SYNC: entered from LOAD when `dwnld`=0. Waits for the first `vs_fall`. That edge restarts `len_cnt` at 1, does not count a frame, does not publish `frame_len`, and moves the FSM to RUN.
  - RUN: each `vs_fall` increments `frame_cnt`.
  - DONE: entered when `frame_cnt` becomes `DUMP_END` (`DUMP_END`≠0). Counting continues.
- `dwnld`=1 has priority over every other event in the same cycle, including a simultaneous `vs_fall`.
- `frame_cnt` wraps from 2^32−1 to 0 with no flag.
- `dump_en` is combinational from registered state. It equals (state∈{RUN}) & (`frame_cnt` ≥ `DUMP_START`) & (`DUMP_END`=0 | `frame_cnt` < `DUMP_END`). It is low in LOAD, SYNC and DONE.
- `finish` pulses in the same cycle the FSM enters DONE. It pulses only once per download cycle.
- Frame length (RUN/DONE):
  - `len_cnt` increments every clock and saturates at all-ones.
  - On `vs_fall`: `frame_len`←`len_cnt`, `len_cnt`←1, `frame_len_vld`=1 for that cycle.
- Stall (RUN/DONE only):
  - `stall` sets when `len_cnt` = `VS_TIMEOUT`.
  - It stays set until the next `vs_fall` (cleared in the same cycle as that strobe), `dwnld`, or `rst`.

## Timing
- Reset values: `frame_cnt`=0, `vs_fall`=0, `dump_en`=0, `finish`=0, `frame_len`=0, `frame_len_vld`=0, `stall`=0, state=LOAD, synchroniser flops=1.
- Latency: if edge k is the first clock edge to sample `vs`=0 after `vs`=1, then `vs_fall` is high for exactly the cycle after edge k+2.
- `frame_cnt`, `frame_len`, `frame_len_vld` and `finish` update at the same edge that registers `vs_fall`. They change coincident with the `vs_fall` strobe, not one cycle later.
- Glitches: VS pulses shorter than one clock may be missed. A VS low level lasting ≥2 clocks is always detected exactly once.
- `dwnld` rising mid-frame: clears everything at the next edge and the FSM returns to LOAD. No `finish` or `frame_len_vld` is emitted.

## Structure
- Shared package `jtframe_frame_pkg`: state enum (LOAD, SYNC, RUN, DONE) and the default `VS_TIMEOUT` constant.
- One sub-module, `jtframe_sync_edge`: 3-flop synchroniser plus registered falling-edge strobe, reset to 1s.
- Remaining logic stays in the top: FSM, counters, window compare.

## Test plan
- Reset, `dwnld` 1→0, then 5 VS pulses 1000 clocks apart → `frame_cnt` reads 0,1,2,3,4. Four `frame_len_vld` strobes, each with `frame_len`=1000.
- `DUMP_START`=2, `DUMP_END`=4, 6 VS pulses → `dump_en` high only while `frame_cnt`∈{2,3}. One `finish` strobe at `frame_cnt`=4. `frame_cnt` ends at 5.
- `VS_TIMEOUT`=500, VS stops after frame 3 → `stall`=1 exactly 500 clocks after the last `vs_fall`. The next VS pulse clears `stall` with its strobe.
- `dwnld` asserted in the same cycle as `vs_fall` at `frame_cnt`=7 → `frame_cnt`=0, state LOAD, no `frame_len_vld`.
- VS low for 1 clock vs. 2 clocks → the 2-clock pulse yields exactly one `vs_fall`, 3 edges after first sampling. Stalling VS low for 10000 clocks yields no extra strobes.
- Force `frame_cnt` to 32'hFFFF_FFFF, one VS pulse → `frame_cnt`=0, no other flag changes.
